display_feeder: RTL and testbench

DISPLAY_FEEDER -- requirements
Module: display_feeder

---
 rtl/display_pkg.sv | 13 +
 rtl/refresh_divider.sv | 28 ++
 rtl/display_feeder.sv | 96 +++++++++
 tb/tb_display_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display feeder: data width, dwell FSM states
// and the dwell counter width (wide enough for DWELL up to 1023).
package display_pkg;

  localparam int DISP_W  = 16;
  localparam int DWELL_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/refresh_divider.sv
// Free-running 0..DIV-1 counter; tick is high for the single cycle in which
// the counter sits at DIV-1.
module refresh_divider #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded straight from the counter so reset forces the strobe low.
  assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/display_feeder.sv
// Feeds 16-bit values to a 4-digit hex scanner. With DISPLAY_FEEDER_DWELL_EN
// defined each accepted value is held for DWELL refresh ticks before the next.
module display_feeder
  import display_pkg::*;
#(
  parameter int DIV   = 25000,
  parameter int DWELL = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DISP_W-1:0] in_data,
  output logic              in_ready,
  output logic [DISP_W-1:0] disp_value,
  output logic              refresh_tick,
  output logic              updated
);

  if (DIV < 2 || DIV > (1 << 20)) begin : g_bad_div
    $error("display_feeder: DIV out of range 2..2^20");
  end
  if (DWELL < 1 || DWELL > 1023) begin : g_bad_dwell
    $error("display_feeder: DWELL out of range 1..1023");
  end

  refresh_divider #(
    .DIV (DIV)
  ) u_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (refresh_tick)
  );

  // Handshake: a value transfers on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_data is ignored otherwise.
  logic handshake;
  assign handshake = in_valid && in_ready;

`ifdef DISPLAY_FEEDER_DWELL_EN

  state_t               state;
  logic [DWELL_W-1:0]   dwell_cnt;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dwell_cnt  <= '0;
      disp_value <= '0;
      updated    <= 1'b0;
    end else begin
      updated <= handshake;
      case (state)
        IDLE: begin
          // A tick in the load cycle does not count against the new dwell.
          if (handshake) begin
            disp_value <= in_data;
            dwell_cnt  <= DWELL_W'(DWELL);
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (refresh_tick) begin
            if (dwell_cnt == DWELL_W'(1)) begin
              dwell_cnt <= '0;
              state     <= IDLE;
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign in_ready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_value <= '0;
      updated    <= 1'b0;
    end else begin
      updated <= handshake;
      if (handshake) begin
        disp_value <= in_data;
      end
    end
  end

`endif

endmodule

// File: tb/tb_display_feeder.sv
// Bench for display_feeder (DIV=4, DWELL=2); reference model predicts outputs
// from cycle index since reset release and the tick/dwell arithmetic.
module tb_display_feeder;

  localparam int DIV   = 4;
  localparam int DWELL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready;
  logic [15:0] disp_value;
  logic        refresh_tick;
  logic        updated;

  always #5 clk = ~clk;

  display_feeder #(
    .DIV   (DIV),
    .DWELL (DWELL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .disp_value   (disp_value),
    .refresh_tick (refresh_tick),
    .updated      (updated)
  );

  int compared = 0;
  int mismatched = 0;

  // Model state: k = cycles since reset release (k=0 is the divider's 0 state).
  int          k;
  logic [15:0] m_disp;
  logic        m_upd;
  int          m_end;   // last cycle of the current dwell; ready afterwards

  logic [18:0] obs;
  logic [18:0] exp_v;

  function automatic logic m_ready();
`ifdef DISPLAY_FEEDER_DWELL_EN
    return k > m_end;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic m_tick();
    return (k % DIV) == DIV - 1;
  endfunction

  // Cycle of the DWELL-th tick strictly after accept cycle a.
  function automatic int dwell_end(input int a);
    return DIV * ((a + 1) / DIV + DWELL - 1) + DIV - 1;
  endfunction

  task automatic model_reset();
    k      = 0;
    m_disp = 16'h0;
    m_upd  = 1'b0;
    m_end  = -1;
  endtask

  // Drive one cycle of inputs at a negedge, advance model, wait next negedge.
  task automatic cycle(input logic v, input logic [15:0] d);
    logic hs;
    in_valid = v;
    in_data  = d;
    hs = v && m_ready();
    m_upd = hs;
    if (hs) begin
      m_disp = d;
      m_end  = dwell_end(k);
    end
    k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int ticks;
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    compared++;
    if ({in_ready, refresh_tick, updated, disp_value} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      mismatched++;
      $display("FAIL reset_hold got %h exp %h", {in_ready, refresh_tick, updated, disp_value},
               {1'b1, 1'b0, 1'b0, 16'h0000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      ticks += int'(refresh_tick);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL reset_idle k=%0d got %h exp %h", k, obs, exp_v);
      end
      cycle(1'b0, 16'h0);
    end
    compared++;
    if (ticks != 3) begin
      mismatched++;
      $display("FAIL reset_tick_count got %0d exp 3", ticks);
    end
  endtask

  task automatic test_accept();
    int n;
    n = 0;
    while (!m_ready() && n < 2000) begin
      cycle(1'b0, 16'h0);
      n++;
    end
    cycle(1'b1, 16'hBEEF);
    for (int i = 0; i < 14; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL accept k=%0d got %h exp %h", k, obs, exp_v);
      end
      cycle(1'b0, 16'($urandom));
    end
  endtask

  task automatic test_blocked();
    int held;
    held = 0;
    while (!m_ready()) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h1234);
    for (int i = 0; i < 16; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      if (disp_value === 16'h1234) held++;
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL blocked k=%0d got %h exp %h", k, obs, exp_v);
      end
      if (m_disp == 16'h5678) cycle(1'b0, 16'h0);
      else cycle(1'b1, 16'h5678);
    end
    compared++;
    if (held < DIV || disp_value !== 16'h5678) begin
      mismatched++;
      $display("FAIL blocked_hold held=%0d disp=%h exp held>=%0d disp=5678", held, disp_value, DIV);
    end
  endtask

  task automatic test_tick_coincide();
    int n;
    n = 0;
    while (!(m_ready() && m_tick()) && n < 2000) begin
      cycle(1'b0, 16'h0);
      n++;
    end
    cycle(1'b1, 16'($urandom));
`ifdef DISPLAY_FEEDER_DWELL_EN
    compared++;
    if (dut.dwell_cnt !== 10'(DWELL)) begin
      mismatched++;
      $display("FAIL coincide_dwell got %0d exp %0d", dut.dwell_cnt, DWELL);
    end
`endif
    for (int i = 0; i < 3 * DIV; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL coincide k=%0d got %h exp %h", k, obs, exp_v);
      end
      cycle(1'b0, 16'h0);
    end
  endtask

  task automatic test_reset_mid_hold();
    while (!m_ready()) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'hA5A5);
    cycle(1'b0, 16'h0);
    compared++;
    if ({in_ready, disp_value} !== {m_ready(), 16'hA5A5}) begin
      mismatched++;
      $display("FAIL midhold_pre got %h exp %h", {in_ready, disp_value}, {m_ready(), 16'hA5A5});
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({in_ready, refresh_tick, updated, disp_value} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      mismatched++;
      $display("FAIL midhold_reset got %h exp %h", {in_ready, refresh_tick, updated, disp_value},
               {1'b1, 1'b0, 1'b0, 16'h0000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * DIV; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL midhold_after k=%0d got %h exp %h", k, obs, exp_v);
      end
      cycle(1'b0, 16'h0);
    end
  endtask

  task automatic test_stream();
    int ups;
    logic [15:0] vals [3];
    vals[0] = 16'h0001;
    vals[1] = 16'h0002;
    vals[2] = 16'h0003;
    ups = 0;
    for (int i = 0; i < 6; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      ups += int'(updated);
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL stream k=%0d got %h exp %h", k, obs, exp_v);
      end
      if (i < 3) cycle(1'b1, vals[i]);
      else cycle(1'b0, 16'h0);
    end
    compared++;
    if (ups != 3 || disp_value !== 16'h0003) begin
      mismatched++;
      $display("FAIL stream_total updates=%0d disp=%h exp 3 and 0003", ups, disp_value);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      obs   = {in_ready, refresh_tick, updated, disp_value};
      exp_v = {m_ready(), m_tick(), m_upd, m_disp};
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("FAIL random k=%0d got %h exp %h", k, obs, exp_v);
      end
      cycle(1'($urandom_range(0, 1)), 16'($urandom));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_accept();
`ifdef DISPLAY_FEEDER_DWELL_EN
    test_blocked();
    test_tick_coincide();
`else
    test_stream();
`endif
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
